// File: rtl/jk_reg_bank_if.sv
// jk_reg_bank_if: control/data bundle for jk_reg_bank
// Master drives en/mode/j/k/err_clr; slave returns q, rise/fall flags and illegal-SR error status.
interface jk_reg_bank_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             i_en;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_j;
  logic [WIDTH-1:0] i_k;
  logic             i_err_clr;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;
  logic             o_sr_err;
  logic [CNT_W-1:0] o_err_cnt;
  modport master (
    output i_en, i_mode, i_j, i_k, i_err_clr,
    input  o_q, o_rise, o_fall, o_sr_err, o_err_cnt
  );
  modport slave (
    input  i_en, i_mode, i_j, i_k, i_err_clr,
    output o_q, o_rise, o_fall, o_sr_err, o_err_cnt
  );
endinterface

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit bank of D/JK/T/SR flip-flops with edge flags and illegal-SR error tracking
// Ports: clk rising-edge clock, rst async active-low reset, bus slave modport
//   (i_en, i_mode 00 D/01 JK/10 T/11 SR, i_j D/J/T/S, i_k K/R, i_err_clr,
//    o_q, o_rise, o_fall, o_sr_err sticky, o_err_cnt saturating).
module jk_reg_bank #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst,
  jk_reg_bank_if.slave bus
);
  logic [WIDTH-1:0] r_q, r_rise, r_fall;
  logic             r_sr_err;
  logic [CNT_W-1:0] r_err_cnt;
  logic [WIDTH-1:0] w_next;
  logic             w_ill;
  logic [CNT_W-1:0] w_cnt_inc;
  // SR: set on S&~R, otherwise hold when S==R (00 and illegal 11), clear on R&~S
  always_comb begin
    w_next = bus.i_mode == 2'b00 ? bus.i_j :
             bus.i_mode == 2'b01 ? (bus.i_j & ~r_q) | (~bus.i_k & r_q) :
             bus.i_mode == 2'b10 ? r_q ^ bus.i_j :
                                   (bus.i_j & ~bus.i_k) | (r_q & ~(bus.i_j ^ bus.i_k));
    w_ill = bus.i_en && bus.i_mode == 2'b11 && |(bus.i_j & bus.i_k);
    w_cnt_inc = r_err_cnt == {CNT_W{1'b1}} ? r_err_cnt : r_err_cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q       <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_sr_err  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (bus.i_en) r_q <= w_next;
      r_rise <= bus.i_en ? w_next & ~r_q : '0;
      r_fall <= bus.i_en ? ~w_next & r_q : '0;
      // a clear coinciding with an illegal edge restarts the count at one
      if (bus.i_err_clr) begin
        r_sr_err  <= w_ill;
        r_err_cnt <= w_ill ? CNT_W'(1) : '0;
      end else if (w_ill) begin
        r_sr_err  <= 1'b1;
        r_err_cnt <= w_cnt_inc;
      end
    end
  end
  assign bus.o_q       = r_q;
  assign bus.o_rise    = r_rise;
  assign bus.o_fall    = r_fall;
  assign bus.o_sr_err  = r_sr_err;
  assign bus.o_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: randomized and directed checks of jk_reg_bank against a per-bit behavioural model
module tb_jk_reg_bank;
  localparam int W = 4;
  localparam int CW = 8;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  logic [W-1:0] m_q = '0, m_rise = '0, m_fall = '0;
  logic m_err = 1'b0;
  int m_cnt = 0;
  jk_reg_bank_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  jk_reg_bank #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded, required finish before 1000000");
    $fatal(1, "watchdog");
  end
  function automatic logic [W-1:0] ref_next(input logic [1:0] md, input logic [W-1:0] q, j, k);
    logic [W-1:0] n;
    for (int i = 0; i < W; i++) begin
      case (md)
        2'd0: n[i] = j[i];
        2'd1: n[i] = (j[i] && k[i]) ? !q[i] : j[i] ? 1'b1 : k[i] ? 1'b0 : q[i];
        2'd2: n[i] = j[i] ? !q[i] : q[i];
        default: n[i] = (j[i] && !k[i]) ? 1'b1 : (!j[i] && k[i]) ? 1'b0 : q[i];
      endcase
    end
    return n;
  endfunction
  task automatic step(input logic en, input logic [1:0] md, input logic [W-1:0] j, k, input logic clr);
    logic [W-1:0] nq;
    logic ill;
    bus.i_en = en;
    bus.i_mode = md;
    bus.i_j = j;
    bus.i_k = k;
    bus.i_err_clr = clr;
    @(posedge clk);
    nq = en ? ref_next(md, m_q, j, k) : m_q;
    m_rise = en ? nq & ~m_q : '0;
    m_fall = en ? ~nq & m_q : '0;
    ill = en && md == 2'd3 && (j & k) != '0;
    if (clr) begin
      m_err = ill;
      m_cnt = ill ? 1 : 0;
    end else if (ill) begin
      m_err = 1'b1;
      if (m_cnt < MAXC) m_cnt++;
    end
    m_q = nq;
    #1;
  endtask
  task automatic test_reset;
    #2;
    total++;
    if ({bus.o_q, bus.o_rise, bus.o_fall, bus.o_sr_err, bus.o_err_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_init: got q=%b rise=%b fall=%b err=%b cnt=%0d, want all 0", bus.o_q, bus.o_rise, bus.o_fall, bus.o_sr_err, bus.o_err_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1, 2'd0, 4'b1010, 4'b0000, 0);
    for (int i = 0; i < 3; i++) step(1, 2'd3, 4'b1010, 4'b1010, 0);
    total++;
    if (bus.o_q !== 4'b1010 || bus.o_err_cnt !== 8'd3) begin
      bad++;
      $display("FAIL reset_pre: got q=%b cnt=%0d, want q=1010 cnt=3", bus.o_q, bus.o_err_cnt);
    end
    #3 rst = 1'b0;
    #1;
    total++;
    if ({bus.o_q, bus.o_rise, bus.o_fall, bus.o_sr_err, bus.o_err_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_async: got q=%b rise=%b fall=%b err=%b cnt=%0d, want all 0", bus.o_q, bus.o_rise, bus.o_fall, bus.o_sr_err, bus.o_err_cnt);
    end
    m_q = '0; m_rise = '0; m_fall = '0; m_err = 1'b0; m_cnt = 0;
    bus.i_en = 1'b1; bus.i_mode = 2'd0; bus.i_j = 4'b1111; bus.i_k = 4'b0000; bus.i_err_clr = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.o_q !== 4'b0000 || bus.o_rise !== 4'b0000) begin
      bad++;
      $display("FAIL reset_held: got q=%b rise=%b, want q=0000 rise=0000", bus.o_q, bus.o_rise);
    end
    #3 rst = 1'b1;
    step(1, 2'd0, 4'b0110, 4'b0000, 0);
    total++;
    if (bus.o_q !== 4'b0110 || bus.o_rise !== 4'b0110 || bus.o_fall !== 4'b0000) begin
      bad++;
      $display("FAIL reset_first_edge: got q=%b rise=%b fall=%b, want q=0110 rise=0110 fall=0000", bus.o_q, bus.o_rise, bus.o_fall);
    end
  endtask
  task automatic test_jk;
    step(1, 2'd0, 4'b0000, 4'b0000, 0);
    step(1, 2'd1, 4'b1010, 4'b0000, 0);
    total++;
    if (bus.o_q !== 4'b1010 || bus.o_rise !== 4'b1010 || bus.o_fall !== 4'b0000) begin
      bad++;
      $display("FAIL jk_set: got q=%b rise=%b fall=%b, want q=1010 rise=1010 fall=0000", bus.o_q, bus.o_rise, bus.o_fall);
    end
    step(1, 2'd1, 4'b1111, 4'b1111, 0);
    total++;
    if (bus.o_q !== 4'b0101 || bus.o_rise !== 4'b0101 || bus.o_fall !== 4'b1010) begin
      bad++;
      $display("FAIL jk_toggle: got q=%b rise=%b fall=%b, want q=0101 rise=0101 fall=1010", bus.o_q, bus.o_rise, bus.o_fall);
    end
  endtask
  task automatic test_t_enable;
    step(1, 2'd2, 4'b0011, 4'b0000, 0);
    total++;
    if (bus.o_q !== 4'b0110) begin
      bad++;
      $display("FAIL t_toggle: got q=%b, want q=0110", bus.o_q);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 2'd2, 4'b1111, 4'b0000, 0);
      total++;
      if (bus.o_q !== 4'b0110 || bus.o_rise !== 4'b0000 || bus.o_fall !== 4'b0000) begin
        bad++;
        $display("FAIL en_hold[%0d]: got q=%b rise=%b fall=%b, want q=0110 rise=0000 fall=0000", i, bus.o_q, bus.o_rise, bus.o_fall);
      end
    end
  endtask
  task automatic test_sr_illegal;
    step(1, 2'd3, 4'b1100, 4'b0110, 0);
    total++;
    if (bus.o_q !== 4'b1100 || bus.o_sr_err !== 1'b1 || bus.o_err_cnt !== 8'd1 || bus.o_rise !== 4'b1000 || bus.o_fall !== 4'b0010) begin
      bad++;
      $display("FAIL sr_illegal: got q=%b err=%b cnt=%0d rise=%b fall=%b, want q=1100 err=1 cnt=1 rise=1000 fall=0010", bus.o_q, bus.o_sr_err, bus.o_err_cnt, bus.o_rise, bus.o_fall);
    end
  endtask
  task automatic test_saturation;
    for (int i = 0; i < 300; i++) step(1, 2'd3, 4'($urandom_range(1, 15)) | 4'b0001, 4'b0001, 0);
    total++;
    if (bus.o_err_cnt !== 8'd255 || bus.o_sr_err !== 1'b1) begin
      bad++;
      $display("FAIL saturate: got cnt=%0d err=%b, want cnt=255 err=1", bus.o_err_cnt, bus.o_sr_err);
    end
  endtask
  task automatic test_clear;
    step(1, 2'd0, 4'b1001, 4'b1111, 1);
    total++;
    if (bus.o_sr_err !== 1'b0 || bus.o_err_cnt !== 8'd0 || bus.o_q !== 4'b1001) begin
      bad++;
      $display("FAIL clr_legal: got err=%b cnt=%0d q=%b, want err=0 cnt=0 q=1001", bus.o_sr_err, bus.o_err_cnt, bus.o_q);
    end
    step(1, 2'd3, 4'b0011, 4'b0010, 0);
    step(1, 2'd3, 4'b0011, 4'b0010, 0);
    step(1, 2'd3, 4'b1000, 4'b1000, 1);
    total++;
    if (bus.o_sr_err !== 1'b1 || bus.o_err_cnt !== 8'd1) begin
      bad++;
      $display("FAIL clr_with_illegal: got err=%b cnt=%0d, want err=1 cnt=1", bus.o_sr_err, bus.o_err_cnt);
    end
    step(0, 2'd1, 4'b0000, 4'b0000, 1);
    total++;
    if (bus.o_sr_err !== 1'b0 || bus.o_err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL clr_disabled: got err=%b cnt=%0d, want err=0 cnt=0", bus.o_sr_err, bus.o_err_cnt);
    end
  endtask
  task automatic test_mode_switch;
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 7) != 0, 2'(i % 4), 4'($urandom), 4'($urandom), $urandom_range(0, 49) == 0);
      total++;
      if (bus.o_q !== m_q || bus.o_rise !== m_rise || bus.o_fall !== m_fall || bus.o_sr_err !== m_err || bus.o_err_cnt !== CW'(m_cnt)) begin
        bad++;
        if (errs++ < 10) $display("FAIL mode_switch[%0d]: got q=%b rise=%b fall=%b err=%b cnt=%0d, want q=%b rise=%b fall=%b err=%b cnt=%0d", i, bus.o_q, bus.o_rise, bus.o_fall, bus.o_sr_err, bus.o_err_cnt, m_q, m_rise, m_fall, m_err, m_cnt);
      end
    end
  endtask
  initial begin
    bus.i_en = 1'b0; bus.i_mode = 2'd0; bus.i_j = '0; bus.i_k = '0; bus.i_err_clr = 1'b0;
    test_reset;
    test_jk;
    test_t_enable;
    test_sr_illegal;
    test_saturation;
    test_clear;
    test_mode_switch;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
